// File: rtl/fwd_hazard_if.sv
// ID-stage request and EX-operand control bundle for the forwarding/hazard unit.
// master = decoder/pipeline side, slave = fwd_hazard_ctrl.
interface fwd_hazard_if #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [REG_W-1:0] id_dest;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             stall;
    logic             ex_valid;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_dest, id_reg_write, id_mem_read, flush,
        input  fwd_a, fwd_b, stall, ex_valid, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_dest, id_reg_write, id_mem_read, flush,
        output fwd_a, fwd_b, stall, ex_valid, stall_count
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// EX-operand forwarding select and load-use stall generation for a 5-stage MIPS pipe.
// Tracks destination state of ID/EX, EX/MEM and MEM/WB in private shadow registers.
module fwd_hazard_ctrl #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic         clk,
    input  logic         reset,
    fwd_hazard_if.slave  bus
);

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_WB  = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             reg_write;
        logic             mem_read;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             uses_rs;
        logic             uses_rt;
    } ex_entry_t;

    // Back-end entries only ever act as producers, so sources are not kept.
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             reg_write;
    } wb_entry_t;

    ex_entry_t        idex_q;
    ex_entry_t        idex_d;
    wb_entry_t        exmem_q;
    wb_entry_t        memwb_q;
    logic [CNT_W-1:0] cnt_q;

    logic             load_in_ex_c;
    logic             src_hit_c;
    logic             stall_c;
    logic [1:0]       fwd_a_c;
    logic [1:0]       fwd_b_c;

    function automatic logic produces(input wb_entry_t e, input logic [REG_W-1:0] src);
        return e.valid && e.reg_write && (e.dest != '0) && (e.dest == src);
    endfunction

    function automatic logic [1:0] pick_sel(input logic             ex_valid,
                                            input logic             uses,
                                            input logic [REG_W-1:0] src,
                                            input wb_entry_t        mem,
                                            input wb_entry_t        wb);
        logic [1:0] sel;
        sel = SEL_RF;
        if (ex_valid && uses) begin
            if (produces(mem, src)) begin
                sel = SEL_MEM;
            end else if (produces(wb, src)) begin
                sel = SEL_WB;
            end
        end
        return sel;
    endfunction

    // Load-use detection against the instruction currently sitting in ID/EX.
    always_comb begin
        load_in_ex_c = 1'b0;
        src_hit_c    = 1'b0;
        stall_c      = 1'b0;
        load_in_ex_c = idex_q.valid && idex_q.mem_read && idex_q.reg_write &&
                       (idex_q.dest != '0);
        src_hit_c    = (bus.id_uses_rs && (bus.id_rs == idex_q.dest)) ||
                       (bus.id_uses_rt && (bus.id_rt == idex_q.dest));
        stall_c      = bus.id_valid && !bus.flush && load_in_ex_c && src_hit_c;
    end

    // Youngest producer wins: EX/MEM is checked before MEM/WB.
    always_comb begin
        fwd_a_c = SEL_RF;
        fwd_b_c = SEL_RF;
        fwd_a_c = pick_sel(idex_q.valid, idex_q.uses_rs, idex_q.rs, exmem_q, memwb_q);
        fwd_b_c = pick_sel(idex_q.valid, idex_q.uses_rt, idex_q.rt, exmem_q, memwb_q);
    end

    // Next ID/EX content: a bubble unless a real, unsquashed, unstalled instruction.
    always_comb begin
        idex_d = '0;
        if (bus.id_valid && !bus.flush && !stall_c) begin
            idex_d.valid     = 1'b1;
            idex_d.dest      = bus.id_dest;
            idex_d.reg_write = bus.id_reg_write;
            idex_d.mem_read  = bus.id_mem_read;
            idex_d.rs        = bus.id_rs;
            idex_d.rt        = bus.id_rt;
            idex_d.uses_rs   = bus.id_uses_rs;
            idex_d.uses_rt   = bus.id_uses_rt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
            cnt_q   <= '0;
        end else begin
            memwb_q           <= exmem_q;
            exmem_q.valid     <= idex_q.valid;
            exmem_q.dest      <= idex_q.dest;
            exmem_q.reg_write <= idex_q.reg_write;
            idex_q            <= idex_d;
            if (stall_c && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.fwd_a       = fwd_a_c;
    assign bus.fwd_b       = fwd_b_c;
    assign bus.stall       = stall_c;
    assign bus.ex_valid    = idex_q.valid;
    assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed hazard sequences plus random traffic
// compared against an instruction-history reference model.
module tb_fwd_hazard_ctrl;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        bit v;
        int rs;
        int rt;
        bit urs;
        bit urt;
        int dest;
        bit rw;
        bit mr;
    } rec_t;

    logic clk;
    logic reset;
    fwd_hazard_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    fwd_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;
    // hist[0] = instruction that entered EX most recently, hist[1]/hist[2] older ones.
    rec_t hist[$];
    int   exp_cnt = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic rec_t mk(bit v, int rs, int rt, bit urs, bit urt, int dest, bit rw, bit mr);
        rec_t r;
        r.v = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt;
        r.dest = dest; r.rw = rw; r.mr = mr;
        return r;
    endfunction

    function automatic rec_t bubble();
        return mk(0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic void model_clear();
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back(bubble());
    endfunction

    // Forward from the nearest older writer of the source register; age 1 -> 2, age 2 -> 1.
    function automatic int exp_fwd(bit use_rt);
        rec_t c;
        int   src;
        c = hist[0];
        if (!c.v || !(use_rt ? c.urt : c.urs)) return 0;
        src = use_rt ? c.rt : c.rs;
        for (int age = 1; age <= 2; age++) begin
            if (hist[age].v && hist[age].rw && hist[age].dest != 0 && hist[age].dest == src)
                return 3 - age;
        end
        return 0;
    endfunction

    function automatic bit exp_stall(rec_t id, bit fl);
        rec_t e;
        e = hist[0];
        if (!id.v || fl) return 0;
        if (!(e.v && e.mr && e.rw && e.dest != 0)) return 0;
        return (id.urs && id.rs == e.dest) || (id.urt && id.rt == e.dest);
    endfunction

    // One pipeline cycle: drive ID inputs, check all outputs, clock, advance the model.
    task automatic step(input bit rst, input rec_t ins, input bit fl);
        bit   st;
        rec_t n;
        reset            = rst;
        bus.id_valid     = ins.v;
        bus.id_rs        = REG_W'(ins.rs);
        bus.id_rt        = REG_W'(ins.rt);
        bus.id_uses_rs   = ins.urs;
        bus.id_uses_rt   = ins.urt;
        bus.id_dest      = REG_W'(ins.dest);
        bus.id_reg_write = ins.rw;
        bus.id_mem_read  = ins.mr;
        bus.flush        = fl;
        #1;
        st = exp_stall(ins, fl);
        if (chk_en) begin
            check("stall", 32'(bus.stall), 32'(st));
            check("fwd_a", 32'(bus.fwd_a), 32'(exp_fwd(0)));
            check("fwd_b", 32'(bus.fwd_b), 32'(exp_fwd(1)));
            check("ex_valid", 32'(bus.ex_valid), 32'(hist[0].v));
            check("stall_count", 32'(bus.stall_count), 32'(exp_cnt));
        end
        @(posedge clk);
        if (rst) begin
            model_clear();
            exp_cnt = 0;
        end else begin
            n = bubble();
            if (ins.v && !fl && !st) n = ins;
            hist.push_front(n);
            void'(hist.pop_back());
            if (st && exp_cnt < int'(CNT_MAX)) exp_cnt++;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, bubble(), 0);
    endtask

    initial begin
        rec_t cur;
        int   c0;
        bit   hold;

        model_clear();
        step(1, bubble(), 0);
        chk_en = 1'b1;

        // Idle after reset: everything quiet.
        idle(3);
        check("idle_cnt", 32'(bus.stall_count), 0);
        check("idle_exv", 32'(bus.ex_valid), 0);

        // add $3 ; sub rs=3 rt=4 -> EX/MEM forward on A.
        step(0, mk(1, 1, 2, 1, 1, 3, 1, 0), 0);
        step(0, mk(1, 3, 4, 1, 1, 8, 1, 0), 0);
        check("sub_fwd_a", 32'(bus.fwd_a), 2);
        check("sub_fwd_b", 32'(bus.fwd_b), 0);
        idle(3);

        // add $3 ; nop ; or rt=3 -> MEM/WB forward on B.
        step(0, mk(1, 1, 2, 1, 1, 3, 1, 0), 0);
        idle(1);
        step(0, mk(1, 6, 3, 1, 1, 7, 1, 0), 0);
        check("or_fwd_b", 32'(bus.fwd_b), 1);
        check("or_fwd_a", 32'(bus.fwd_a), 0);
        idle(3);

        // Two writers of $3: youngest wins.
        step(0, mk(1, 1, 2, 1, 1, 3, 1, 0), 0);
        step(0, mk(1, 1, 2, 1, 1, 3, 1, 0), 0);
        step(0, mk(1, 3, 9, 1, 1, 10, 1, 0), 0);
        check("and_fwd_a", 32'(bus.fwd_a), 2);
        idle(3);

        // Same shape writing $0: never forwarded.
        step(0, mk(1, 1, 2, 1, 1, 0, 1, 0), 0);
        step(0, mk(1, 1, 2, 1, 1, 0, 1, 0), 0);
        step(0, mk(1, 0, 9, 1, 1, 10, 1, 0), 0);
        check("zero_fwd_a", 32'(bus.fwd_a), 0);
        idle(3);

        // lw $5 ; add rs=5 -> one stall cycle, bubble, then MEM/WB forward.
        c0 = exp_cnt;
        step(0, mk(1, 1, 2, 1, 0, 5, 1, 1), 0);
        step(0, mk(1, 5, 6, 1, 1, 11, 1, 0), 0);
        check("lu_bubble", 32'(bus.ex_valid), 0);
        check("lu_cnt", 32'(bus.stall_count), 32'(c0 + 1));
        check("lu_once", 32'(bus.stall), 0);
        step(0, mk(1, 5, 6, 1, 1, 11, 1, 0), 0);
        check("lu_fwd_a", 32'(bus.fwd_a), 1);
        check("lu_exv", 32'(bus.ex_valid), 1);
        idle(3);

        // Flush beats a load-use stall.
        c0 = exp_cnt;
        step(0, mk(1, 1, 2, 1, 0, 5, 1, 1), 0);
        step(0, mk(1, 5, 6, 1, 1, 11, 1, 0), 1);
        check("fl_exv", 32'(bus.ex_valid), 0);
        check("fl_cnt", 32'(bus.stall_count), 32'(c0));
        idle(3);

        // Reset during an active stall clears everything.
        step(0, mk(1, 1, 2, 1, 0, 5, 1, 1), 0);
        step(1, mk(1, 5, 6, 1, 1, 11, 1, 0), 0);
        check("rst_exv", 32'(bus.ex_valid), 0);
        check("rst_cnt", 32'(bus.stall_count), 0);
        check("rst_fwd_a", 32'(bus.fwd_a), 0);
        check("rst_fwd_b", 32'(bus.fwd_b), 0);
        check("rst_stall", 32'(bus.stall), 0);

        // Random traffic over a small register set; ID is held while stalled.
        cur  = bubble();
        hold = 1'b0;
        for (int i = 0; i < 600; i++) begin
            bit rst;
            bit fl;
            if (!hold) begin
                cur = mk($urandom_range(3, 0) != 0, $urandom_range(5, 0), $urandom_range(5, 0),
                         $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1,
                         $urandom_range(5, 0), $urandom_range(3, 0) != 0,
                         $urandom_range(2, 0) == 0);
            end
            rst  = ($urandom_range(49, 0) == 0);
            fl   = ($urandom_range(7, 0) == 0);
            hold = !rst && exp_stall(cur, fl);
            step(rst, cur, fl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Control block that generates the 2-bit select inputs for the EX-stage operand three-way muxes in the 5-stage MIPS pipeline.
- Keeps its own shadow of the ID/EX, EX/MEM and MEM/WB register-destination state, one entry per stage.
- From that state it drives forwarding selects, raises a load-use stall and inserts a bubble.
- Sits beside the pipeline registers. It is fed by the decoder (ID stage) and feeds the ALU operand muxes, the PC write-enable and the IF/ID write-enable.

Parameters:
- REG_W, 5, register-specifier width
- CNT_W, 16, width of the saturating stall counter

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  synchronous, active-high
- id_valid  input  1  ID stage holds a real instruction
- id_rs  input  REG_W  source register A of the ID instruction
- id_rt  input  REG_W  source register B of the ID instruction
- id_uses_rs  input  1  ID instruction reads rs
- id_uses_rt  input  1  ID instruction reads rt
- id_dest  input  REG_W  destination register of the ID instruction
- id_reg_write  input  1  ID instruction writes the register file
- id_mem_read  input  1  ID instruction is a load
- flush  input  1  squash the ID instruction (taken branch/jump)
- fwd_a  output  2  select for operand-A mux: 0 = register file, 1 = MEM/WB result, 2 = EX/MEM result
- fwd_b  output  2  select for operand-B mux, same encoding as fwd_a
- stall  output  1  hold PC and IF/ID; ID/EX receives a bubble
- ex_valid  output  1  ID/EX shadow entry is valid
- stall_count  output  CNT_W  number of stall cycles, saturating

Behaviour:
- Each shadow entry holds: valid, dest, reg_write, mem_read, rs, rt, uses_rs, uses_rt. Only ID/EX uses the source fields.
- Reset (synchronous, active-high):
  - all entries have valid = 0;
  - stall_count = 0;
  - fwd_a = fwd_b = 0, stall = 0, ex_valid = 0 in the cycle after reset is sampled.
- Stall is combinational. It is 1 only when all of the following hold:
  - id_valid = 1 and flush = 0;
  - ID/EX entry has valid, mem_read and reg_write set, and dest != 0;
  - (id_uses_rs and id_rs == dest) or (id_uses_rt and id_rt == dest).
- On each clk edge when reset = 0:
  - MEM/WB <= EX/MEM.
  - EX/MEM <= ID/EX.
  - ID/EX <= bubble (valid = 0) if stall, flush or !id_valid. Otherwise ID/EX <= the ID inputs with valid = 1.
  - The back end never stalls; all entries advance every cycle.
- Forwarding selects are combinational from the shadow state only (no dependence on ID inputs). For operand A (B is identical using rt/uses_rt):
  - 0 if ID/EX is invalid or uses_rs = 0;
  - 2 if EX/MEM is valid, reg_write = 1, dest != 0 and dest == ID/EX.rs;
  - otherwise 1 if MEM/WB meets the same conditions;
  - otherwise 0.
- EX/MEM has priority over MEM/WB, so the youngest producer wins.
- Register $0 is never forwarded and never causes a stall.
- A load in EX/MEM selects 2. This case is unreachable after a correct stall and needs no special handling.
- Select value 3 is never driven.
- ex_valid = ID/EX.valid.
- stall_count increments by 1 on every edge where stall = 1 and reset = 0. It holds at 2^CNT_W-1 once it reaches that value.
- flush and a stall condition in the same cycle: flush wins, stall = 0, one bubble is inserted.
- During a stall the ID inputs are held by the upstream IF/ID. On the next cycle the load has moved to EX/MEM, stall drops, and the consumer enters ID/EX with fwd = 1 one cycle later.
- Reset asserted mid-stream discards all in-flight entries. The first cycle after reset never stalls or forwards.

Test Plan:
- Reset, then 3 idle cycles (id_valid = 0) -> fwd_a = fwd_b = 0, stall = 0, stall_count = 0, ex_valid = 0 throughout.
- add $3 (dest 3, reg_write) followed by sub using rs = 3, rt = 4 -> in sub's EX cycle fwd_a = 2, fwd_b = 0.
- add $3, nop, then or using rt = 3 -> in or's EX cycle fwd_b = 1, fwd_a = 0.
- add $3 followed by add $3 and then and using rs = 3 -> and's EX cycle has fwd_a = 2 (youngest producer). With the same sequence writing dest 0 -> fwd_a = 0.
- lw $5 followed by add using rs = 5:
  - stall = 1 for exactly 1 cycle and stall_count = 1;
  - a bubble enters ID/EX (ex_valid = 0 in the next cycle);
  - add's EX cycle has fwd_a = 1.
- lw $5 with flush = 1 asserted while the dependent add is in ID -> stall = 0, stall_count unchanged, ex_valid = 0 next cycle. Separately, assert reset while a stall is active -> all outputs are 0 on the next cycle.
